// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, functs,
// ALU codes, datapath select values and trap causes.
package mc_pkg;

   typedef logic [3:0] state_t;

   localparam state_t FETCH   = 4'd0;
   localparam state_t DECODE  = 4'd1;
   localparam state_t MEMADR  = 4'd2;
   localparam state_t MEMRD   = 4'd3;
   localparam state_t MEMWB   = 4'd4;
   localparam state_t MEMWR   = 4'd5;
   localparam state_t RTYPEEX = 4'd6;
   localparam state_t RTYPEWB = 4'd7;
   localparam state_t BEQEX   = 4'd8;
   localparam state_t BNEEX   = 4'd9;
   localparam state_t IMMEX   = 4'd10;
   localparam state_t IMMWB   = 4'd11;
   localparam state_t JEX     = 4'd12;
   localparam state_t JALEX   = 4'd13;
   localparam state_t TRAP    = 4'd14;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0010;
   localparam logic [3:0] ALU_AND = 4'b0100;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_SLT = 4'b1010;

   // Operation class handed from the FSM to the ALU decoder.
   localparam logic [2:0] ALUOP_ADD   = 3'd0;
   localparam logic [2:0] ALUOP_SUB   = 3'd1;
   localparam logic [2:0] ALUOP_AND   = 3'd2;
   localparam logic [2:0] ALUOP_OR    = 3'd3;
   localparam logic [2:0] ALUOP_SLT   = 3'd4;
   localparam logic [2:0] ALUOP_FUNCT = 3'd5;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] MTR_ALUOUT = 2'b00;
   localparam logic [1:0] MTR_DATA   = 2'b01;
   localparam logic [1:0] MTR_PC     = 2'b10;

   localparam logic [1:0] RDST_RT = 2'b00;
   localparam logic [1:0] RDST_RD = 2'b01;
   localparam logic [1:0] RDST_RA = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's operation class (and funct for R-type) to an
// ALU control code, flagging functs the datapath does not implement.
module mc_aludec
   import mc_pkg::*;
(
   input  logic [2:0] aluop,
   input  logic [5:0] funct,
   output logic [3:0] alucontrol,
   output logic       illegal_funct
);

   always_comb begin
      alucontrol    = ALU_ADD;
      illegal_funct = 1'b0;
      case (aluop)
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_AND: alucontrol = ALU_AND;
         ALUOP_OR:  alucontrol = ALU_OR;
         ALUOP_SLT: alucontrol = ALU_SLT;
         ALUOP_FUNCT: begin
            case (funct)
               F_ADD:   alucontrol = ALU_ADD;
               F_SUB:   alucontrol = ALU_SUB;
               F_AND:   alucontrol = ALU_AND;
               F_OR:    alucontrol = ALU_OR;
               F_SLT:   alucontrol = ALU_SLT;
               default: illegal_funct = 1'b1;
            endcase
         end
         default:   alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multicycle MIPS control unit with memory ready handshake, wait-state timeout,
// extended immediate/branch/link instructions and a sticky trap state.
module mc_ctrl_hs
   import mc_pkg::*;
#(
   parameter int unsigned ALUCTRL_W = 4,
   parameter int unsigned WAIT_MAX  = 15,
   parameter bit          EXT_EN    = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [5:0]           op,
   input  logic [5:0]           funct,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 memreq,
   output logic                 memwrite,
   output logic                 irwrite,
   output logic                 pcen,
   output logic                 regwrite,
   output logic                 alusrca,
   output logic [1:0]           alusrcb,
   output logic                 immzx,
   output logic                 iord,
   output logic [1:0]           memtoreg,
   output logic [1:0]           regdst,
   output logic [1:0]           pcsrc,
   output logic [ALUCTRL_W-1:0] alucontrol,
   output logic                 trap,
   output logic [1:0]           trap_cause
);

   state_t     state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic [1:0] cause_q, cause_d;
   logic [2:0] aluop;
   logic [3:0] alu4;
   logic       illegal_funct;
   logic       mem_state;
   logic       timeout;

   mc_aludec u_aludec (
      .aluop        (aluop),
      .funct        (funct),
      .alucontrol   (alu4),
      .illegal_funct(illegal_funct)
   );

   assign mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
   // Counter holds the number of stalled cycles already seen in this access.
   assign timeout   = mem_state && !mem_ready && (wait_q == 8'(WAIT_MAX - 1));
   assign wait_d    = (mem_state && !mem_ready) ? wait_q + 8'd1 : 8'd0;

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         FETCH:   if (mem_ready) state_d = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW:              state_d = MEMADR;
               OP_RTYPE:                  state_d = RTYPEEX;
               OP_BEQ:                    state_d = BEQEX;
               OP_ADDI:                   state_d = IMMEX;
               OP_J:                      state_d = JEX;
               OP_BNE:                    state_d = EXT_EN ? BNEEX : TRAP;
               OP_SLTI, OP_ANDI, OP_ORI:  state_d = EXT_EN ? IMMEX : TRAP;
               OP_JAL:                    state_d = EXT_EN ? JALEX : TRAP;
               default:                   state_d = TRAP;
            endcase
         end
         MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   if (mem_ready) state_d = MEMWB;
         MEMWR:   if (mem_ready) state_d = FETCH;
         RTYPEEX: state_d = illegal_funct ? TRAP : RTYPEWB;
         IMMEX:   state_d = IMMWB;
         TRAP:    state_d = TRAP;
         default: state_d = FETCH;
      endcase
      if (timeout) state_d = TRAP;
      if ((state_d == TRAP) && (state_q != TRAP)) begin
         cause_d = timeout ? CAUSE_TIMEOUT : CAUSE_ILLEGAL;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH;
         wait_q  <= 8'd0;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      memreq   = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      pcen     = 1'b0;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = SRCB_B;
      immzx    = 1'b0;
      iord     = 1'b0;
      memtoreg = MTR_ALUOUT;
      regdst   = RDST_RT;
      pcsrc    = PCSRC_ALU;
      aluop    = ALUOP_ADD;
      if (reset) begin
         case (state_q)
            FETCH: begin
               memreq  = 1'b1;
               alusrcb = SRCB_FOUR;
               irwrite = mem_ready;
               pcen    = mem_ready;
            end
            DECODE:  alusrcb = SRCB_IMMSH;
            MEMADR: begin
               alusrca = 1'b1;
               alusrcb = SRCB_IMM;
            end
            MEMRD: begin
               memreq = 1'b1;
               iord   = 1'b1;
            end
            MEMWB: begin
               regwrite = 1'b1;
               memtoreg = MTR_DATA;
            end
            MEMWR: begin
               memreq   = 1'b1;
               memwrite = 1'b1;
               iord     = 1'b1;
            end
            RTYPEEX: begin
               alusrca = 1'b1;
               aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
               regwrite = 1'b1;
               regdst   = RDST_RD;
            end
            BEQEX, BNEEX: begin
               alusrca = 1'b1;
               aluop   = ALUOP_SUB;
               pcsrc   = PCSRC_ALUOUT;
               pcen    = (state_q == BEQEX) ? zero : !zero;
            end
            IMMEX: begin
               alusrca = 1'b1;
               alusrcb = SRCB_IMM;
               case (op)
                  OP_SLTI: aluop = ALUOP_SLT;
                  OP_ANDI: begin
                     aluop = ALUOP_AND;
                     immzx = 1'b1;
                  end
                  OP_ORI: begin
                     aluop = ALUOP_OR;
                     immzx = 1'b1;
                  end
                  default: aluop = ALUOP_ADD;
               endcase
            end
            IMMWB:   regwrite = 1'b1;
            JEX: begin
               pcen  = 1'b1;
               pcsrc = PCSRC_JUMP;
            end
            JALEX: begin
               regwrite = 1'b1;
               regdst   = RDST_RA;
               memtoreg = MTR_PC;
               pcen     = 1'b1;
               pcsrc    = PCSRC_JUMP;
            end
            default: ;
         endcase
      end
   end

   assign alucontrol = reset ? ALUCTRL_W'(alu4) : '0;
   assign trap       = reset && (state_q == TRAP);
   assign trap_cause = trap ? cause_q : CAUSE_NONE;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Randomized bench: two controllers (full ISA / WAIT_MAX 15, and base ISA /
// WAIT_MAX 4 / wide alucontrol) checked every cycle against a step-list model.
module tb_mc_ctrl_hs;

   localparam int unsigned WMAX0 = 15;
   localparam int unsigned WMAX1 = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]      reset_s, zero_s, rdy_s;
   logic [1:0][5:0] op_s, funct_s;
   logic [1:0]      memreq_s, memwrite_s, irwrite_s, pcen_s, regwrite_s;
   logic [1:0]      alusrca_s, immzx_s, iord_s, trap_s;
   logic [1:0][1:0] alusrcb_s, memtoreg_s, regdst_s, pcsrc_s, cause_s;
   logic [3:0]      alu0;
   logic [5:0]      alu1;

   mc_ctrl_hs #(.ALUCTRL_W(4), .WAIT_MAX(WMAX0), .EXT_EN(1'b1)) dut0 (
      .clk(clk), .reset(reset_s[0]), .op(op_s[0]), .funct(funct_s[0]), .zero(zero_s[0]),
      .mem_ready(rdy_s[0]), .memreq(memreq_s[0]), .memwrite(memwrite_s[0]),
      .irwrite(irwrite_s[0]), .pcen(pcen_s[0]), .regwrite(regwrite_s[0]),
      .alusrca(alusrca_s[0]), .alusrcb(alusrcb_s[0]), .immzx(immzx_s[0]), .iord(iord_s[0]),
      .memtoreg(memtoreg_s[0]), .regdst(regdst_s[0]), .pcsrc(pcsrc_s[0]), .alucontrol(alu0),
      .trap(trap_s[0]), .trap_cause(cause_s[0])
   );

   mc_ctrl_hs #(.ALUCTRL_W(6), .WAIT_MAX(WMAX1), .EXT_EN(1'b0)) dut1 (
      .clk(clk), .reset(reset_s[1]), .op(op_s[1]), .funct(funct_s[1]), .zero(zero_s[1]),
      .mem_ready(rdy_s[1]), .memreq(memreq_s[1]), .memwrite(memwrite_s[1]),
      .irwrite(irwrite_s[1]), .pcen(pcen_s[1]), .regwrite(regwrite_s[1]),
      .alusrca(alusrca_s[1]), .alusrcb(alusrcb_s[1]), .immzx(immzx_s[1]), .iord(iord_s[1]),
      .memtoreg(memtoreg_s[1]), .regdst(regdst_s[1]), .pcsrc(pcsrc_s[1]), .alucontrol(alu1),
      .trap(trap_s[1]), .trap_cause(cause_s[1])
   );

   // Model: current step name plus the remaining steps of the decoded instruction.
   string      cur [2];
   string      plan [2][3];
   int         plen [2], pidx [2], waits [2], trap_age [2], stall [2];
   logic [1:0] mcause [2];
   int         n_chk = 0;
   int         n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
   endtask

   function automatic logic [4:0] rtype_alu(input logic [5:0] f);
      case (f)
         6'b100000: return {1'b1, 4'b0000};
         6'b100010: return {1'b1, 4'b0010};
         6'b100100: return {1'b1, 4'b0100};
         6'b100101: return {1'b1, 4'b0101};
         6'b101010: return {1'b1, 4'b1010};
         default:   return 5'b0;
      endcase
   endfunction

   task automatic set_plan(input int k, input string a, input string b, input string c,
                           input int n);
      plan[k][0] = a;
      plan[k][1] = b;
      plan[k][2] = c;
      plen[k]    = n;
   endtask

   task automatic advance(input int k);
      if (pidx[k] < plen[k]) begin
         cur[k] = plan[k][pidx[k]];
         pidx[k]++;
      end else begin
         cur[k] = "fetch";
      end
      waits[k] = 0;
   endtask

   task automatic do_decode(input int k);
      bit ext;
      ext     = (k == 0);
      pidx[k] = 0;
      plen[k] = 0;
      case (op_s[k])
         6'b100011: set_plan(k, "adr", "rd", "mwb", 3);
         6'b101011: set_plan(k, "adr", "wr", "", 2);
         6'b000000: set_plan(k, "rex", "rwb", "", 2);
         6'b000100: set_plan(k, "beq", "", "", 1);
         6'b001000: set_plan(k, "iex", "iwb", "", 2);
         6'b000010: set_plan(k, "j", "", "", 1);
         6'b000101: if (ext) set_plan(k, "bne", "", "", 1);
         6'b001010, 6'b001100, 6'b001101: if (ext) set_plan(k, "iex", "iwb", "", 2);
         6'b000011: if (ext) set_plan(k, "jal", "", "", 1);
         default: ;
      endcase
      if (plen[k] == 0) begin
         cur[k]    = "trap";
         mcause[k] = 2'b01;
      end else begin
         advance(k);
      end
   endtask

   task automatic model_step(input int k);
      int         wmax;
      logic [4:0] rt;
      wmax = (k == 0) ? WMAX0 : WMAX1;
      rt   = rtype_alu(funct_s[k]);
      if (!reset_s[k]) begin
         cur[k]    = "fetch";
         waits[k]  = 0;
         mcause[k] = 2'b00;
      end else if (cur[k] == "trap") begin
         cur[k] = "trap";
      end else if (cur[k] == "fetch" || cur[k] == "rd" || cur[k] == "wr") begin
         if (rdy_s[k]) begin
            if (cur[k] == "fetch") begin
               cur[k]   = "decode";
               waits[k] = 0;
            end else begin
               advance(k);
            end
         end else begin
            waits[k]++;
            if (waits[k] == wmax) begin
               cur[k]    = "trap";
               mcause[k] = 2'b10;
            end
         end
      end else if (cur[k] == "decode") begin
         do_decode(k);
      end else if (cur[k] == "rex" && !rt[4]) begin
         cur[k]    = "trap";
         mcause[k] = 2'b01;
      end else begin
         advance(k);
      end
   endtask

   task automatic expect_outs(input int k, output logic [22:0] e, output bit dc);
      logic       mr, mw, irw, pce, rw, asa, izx, iod, trp;
      logic [1:0] asb, mtr, rdst, pcs, cs;
      logic [3:0] alu;
      logic [4:0] rt;
      {mr, mw, irw, pce, rw, asa, izx, iod, trp} = '0;
      {asb, mtr, rdst, pcs, cs} = '0;
      alu = 4'b0000;
      dc  = 1'b0;
      rt  = rtype_alu(funct_s[k]);
      if (reset_s[k]) begin
         if (cur[k] == "fetch") begin
            mr = 1'b1; asb = 2'b01; irw = rdy_s[k]; pce = rdy_s[k];
         end else if (cur[k] == "decode") begin
            asb = 2'b11;
         end else if (cur[k] == "adr") begin
            asa = 1'b1; asb = 2'b10;
         end else if (cur[k] == "rd") begin
            mr = 1'b1; iod = 1'b1;
         end else if (cur[k] == "mwb") begin
            rw = 1'b1; mtr = 2'b01;
         end else if (cur[k] == "wr") begin
            mr = 1'b1; mw = 1'b1; iod = 1'b1;
         end else if (cur[k] == "rex") begin
            asa = 1'b1; alu = rt[3:0]; dc = !rt[4];
         end else if (cur[k] == "rwb") begin
            rw = 1'b1; rdst = 2'b01;
         end else if (cur[k] == "beq" || cur[k] == "bne") begin
            asa = 1'b1; alu = 4'b0010; pcs = 2'b01;
            pce = (cur[k] == "beq") ? zero_s[k] : !zero_s[k];
         end else if (cur[k] == "iex") begin
            asa = 1'b1; asb = 2'b10;
            case (op_s[k])
               6'b001010: alu = 4'b1010;
               6'b001100: begin alu = 4'b0100; izx = 1'b1; end
               6'b001101: begin alu = 4'b0101; izx = 1'b1; end
               default:   alu = 4'b0000;
            endcase
         end else if (cur[k] == "iwb") begin
            rw = 1'b1;
         end else if (cur[k] == "j") begin
            pce = 1'b1; pcs = 2'b10;
         end else if (cur[k] == "jal") begin
            rw = 1'b1; rdst = 2'b10; mtr = 2'b10; pce = 1'b1; pcs = 2'b10;
         end else if (cur[k] == "trap") begin
            trp = 1'b1; cs = mcause[k];
         end
      end
      e = {mr, mw, irw, pce, rw, asa, asb, izx, iod, mtr, rdst, pcs, alu, trp, cs};
   endtask

   function automatic logic [22:0] observed(input int k);
      logic [3:0] a;
      a = (k == 0) ? alu0 : alu1[3:0];
      return {memreq_s[k], memwrite_s[k], irwrite_s[k], pcen_s[k], regwrite_s[k],
              alusrca_s[k], alusrcb_s[k], immzx_s[k], iord_s[k], memtoreg_s[k],
              regdst_s[k], pcsrc_s[k], a, trap_s[k], cause_s[k]};
   endfunction

   task automatic drive(input int k, input int c);
      int wmax;
      wmax = (k == 0) ? WMAX0 : WMAX1;
      if (cur[k] == "trap") trap_age[k]++;
      else trap_age[k] = 0;
      reset_s[k] = !(c < 2 || trap_age[k] > 2 || $urandom_range(0, 79) == 0);
      // The instruction register only changes while fetching.
      if (cur[k] == "fetch" || cur[k] == "trap") begin
         case ($urandom_range(0, 12))
            0:       op_s[k] = 6'b100011;
            1:       op_s[k] = 6'b101011;
            2, 3:    op_s[k] = 6'b000000;
            4:       op_s[k] = 6'b000100;
            5:       op_s[k] = 6'b000101;
            6:       op_s[k] = 6'b001000;
            7:       op_s[k] = 6'b001010;
            8:       op_s[k] = 6'b001100;
            9:       op_s[k] = 6'b001101;
            10:      op_s[k] = 6'b000010;
            11:      op_s[k] = 6'b000011;
            default: op_s[k] = ($urandom_range(0, 1) == 1) ? 6'b111111 : 6'($urandom);
         endcase
         case ($urandom_range(0, 5))
            0:       funct_s[k] = 6'b100000;
            1:       funct_s[k] = 6'b100010;
            2:       funct_s[k] = 6'b100100;
            3:       funct_s[k] = 6'b100101;
            4:       funct_s[k] = 6'b101010;
            default: funct_s[k] = 6'($urandom);
         endcase
      end
      zero_s[k] = 1'($urandom);
      if (stall[k] > 0) begin
         rdy_s[k] = 1'b0;
         stall[k]--;
      end else if ($urandom_range(0, 9) == 0) begin
         rdy_s[k] = 1'b0;
         stall[k] = int'($urandom_range(1, wmax + 1)) - 1;
      end else begin
         rdy_s[k] = ($urandom_range(0, 3) != 0);
      end
   endtask

   initial begin
      logic [22:0] ex, ob;
      bit          dc;
      reset_s = '0;
      zero_s  = '0;
      rdy_s   = '0;
      op_s    = '0;
      funct_s = '0;
      for (int k = 0; k < 2; k++) begin
         cur[k]      = "fetch";
         plen[k]     = 0;
         pidx[k]     = 0;
         waits[k]    = 0;
         trap_age[k] = 0;
         stall[k]    = 0;
         mcause[k]   = 2'b00;
      end
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            expect_outs(k, ex, dc);
            ob = observed(k);
            if (dc) ob[6:3] = ex[6:3];
            check($sformatf("dut%0d_%s", k, cur[k]), 32'(ob), 32'(ex));
         end
         check("dut1_alucontrol_hi", 32'(alu1[5:4]), 32'd0);
         for (int k = 0; k < 2; k++) model_step(k);
         @(posedge clk);
         #1;
         for (int k = 0; k < 2; k++) drive(k, c);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
